// File: rtl/controle_display.sv
// Four-digit BCD display sequencer: double-dabble conversion of a loaded value,
// leading-zero suppression and whole-display blink flags for the 7-segment decoders.
module controle_display #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] valor,
    input  logic        carregar,
    input  logic        piscar,
    output logic        ocupado,
    output logic        pronto,
    output logic [15:0] digitos,
    output logic [7:0]  flags
);

    localparam int              PW         = $clog2(BLINK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(BLINK_DIV - 1);
    localparam logic [13:0]     VALOR_MAX  = 14'd9999;
    localparam logic [3:0]      ULTIMA_ITER = 4'd13;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        ATUALIZA
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   bcd_aj;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   digitos_q, digitos_d;
    logic [2:0]    lz_q, lz_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          fase_q, fase_d;
    logic          apagar;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            digitos_q <= '0;
            lz_q      <= 3'b111;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            presc_q   <= '0;
            fase_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            digitos_q <= digitos_d;
            lz_q      <= lz_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            presc_q   <= presc_d;
            fase_q    <= fase_d;
        end
    end

    // Add-3 correction applied before each shift of the conversion
    always_comb begin
        bcd_aj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_aj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        digitos_d = digitos_q;
        lz_d      = lz_q;
        pronto_d  = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (carregar) begin
                    bin_d    = (valor > VALOR_MAX) ? VALOR_MAX : valor;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    estado_d = CONVERTE;
                end
            end
            CONVERTE: begin
                bin_d = {bin_q[12:0], 1'b0};
                bcd_d = {bcd_aj[14:0], bin_q[13]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ULTIMA_ITER) begin
                    estado_d = ATUALIZA;
                end
            end
            ATUALIZA: begin
                digitos_d = bcd_q;
                lz_d[2]   = (bcd_q[15:12] == 4'd0);
                lz_d[1]   = lz_d[2] && (bcd_q[11:8] == 4'd0);
                lz_d[0]   = lz_d[1] && (bcd_q[7:4] == 4'd0);
                pronto_d  = 1'b1;
                estado_d  = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    // Blink prescaler; held clear while disabled so blink starts visible
    always_comb begin
        presc_d = presc_q;
        fase_d  = fase_q;
        if (!piscar) begin
            presc_d = '0;
            fase_d  = 1'b0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            fase_d  = ~fase_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign apagar  = piscar & fase_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
    assign digitos = digitos_q;
    assign flags   = {apagar, lz_q[2], apagar, lz_q[1], apagar, lz_q[0], apagar, 1'b0};

endmodule
